// File: rtl/lcd_text_buffer_if.sv
// Character-stream, read-port and status bundle between the text source,
// lcd_text_buffer and the LCD controller.
interface lcd_text_buffer_if;
  logic       in_valid;
  logic [7:0] in_char;
  logic       in_ready;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       frame_done;
  logic       dirty;
  logic [4:0] cursor;
  logic       busy;

  // Driver side: byte source plus the LCD controller's read/frame signals.
  modport master (
    output in_valid, in_char, rd_addr, frame_done,
    input  in_ready, rd_data, dirty, cursor, busy
  );

  // Buffer side.
  modport slave (
    input  in_valid, in_char, rd_addr, frame_done,
    output in_ready, rd_data, dirty, cursor, busy
  );
endinterface

// File: rtl/lcd_text_buffer.sv
// 2x16 text image for the LCD controller. Bytes arrive over valid/ready,
// printable characters land at an auto-advancing cursor, a few control codes
// move the cursor or clear the screen. The controller reads cells through a
// registered read port and watches the dirty flag to know when to refresh.
module lcd_text_buffer #(
  parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              rst,
  lcd_text_buffer_if.slave  bus
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam logic [7:0] CHAR_BS = 8'h08;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_FF = 8'h0C;
  localparam logic [7:0] CHAR_CR = 8'h0D;

  state_t     state_reg, state_next;
  logic [4:0] clr_cnt_reg, clr_cnt_next;
  logic [4:0] cursor_reg, cursor_next;
  logic       dirty_reg, dirty_next;
  logic [7:0] rd_data_reg;

  // Display image; cell index = {line, column}.
  logic [7:0] mem [32];

  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       set_dirty;
  logic       accept;
  logic       printable;

  assign accept    = bus.in_valid && (state_reg == ST_IDLE);
  assign printable = (bus.in_char >= 8'h20) && (bus.in_char <= 8'h7E);

  // Next-state, cursor movement and the single array write port.
  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    cursor_next  = cursor_reg;
    set_dirty    = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = cursor_reg;
    wr_data      = bus.in_char;
    case (state_reg)
      ST_CLEAR: begin
        wr_en        = 1'b1;
        wr_addr      = clr_cnt_reg;
        wr_data      = CLEAR_CHAR;
        clr_cnt_next = clr_cnt_reg + 5'd1;
        if (clr_cnt_reg == 5'd31) begin
          state_next = ST_IDLE;
          set_dirty  = 1'b1;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          if (printable) begin
            wr_en       = 1'b1;
            cursor_next = cursor_reg + 5'd1;
            set_dirty   = 1'b1;
          end else begin
            case (bus.in_char)
              CHAR_CR: cursor_next = {cursor_reg[4], 4'h0};
              CHAR_LF: cursor_next = {~cursor_reg[4], cursor_reg[3:0]};
              CHAR_BS: begin
                // Backspace at the home cell is swallowed silently.
                if (cursor_reg != 5'd0) begin
                  cursor_next = cursor_reg - 5'd1;
                  wr_en       = 1'b1;
                  wr_addr     = cursor_reg - 5'd1;
                  wr_data     = CLEAR_CHAR;
                  set_dirty   = 1'b1;
                end
              end
              CHAR_FF: begin
                cursor_next  = 5'd0;
                clr_cnt_next = 5'd0;
                state_next   = ST_CLEAR;
              end
              default: ;
            endcase
          end
        end
      end
      default: state_next = ST_CLEAR;
    endcase
  end

  // A change to the image outranks the controller's frame acknowledgement.
  always_comb begin
    dirty_next = dirty_reg;
    if (set_dirty)
      dirty_next = 1'b1;
    else if (bus.frame_done)
      dirty_next = 1'b0;
  end

  // Control state; reset restarts the clear sequence from cell 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_CLEAR;
      clr_cnt_reg <= 5'd0;
      cursor_reg  <= 5'd0;
      dirty_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
      cursor_reg  <= cursor_next;
      dirty_reg   <= dirty_next;
    end
  end

  // Array write port; contents are not reset, the clear sequence rewrites them.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
  end

  // Registered read port; a same-cycle write to the same cell is not seen yet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rd_data_reg <= 8'h00;
    else
      rd_data_reg <= mem[bus.rd_addr];
  end

  assign bus.in_ready = (state_reg == ST_IDLE);
  assign bus.busy     = (state_reg == ST_CLEAR);
  assign bus.cursor   = cursor_reg;
  assign bus.dirty    = dirty_reg;
  assign bus.rd_data  = rd_data_reg;

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Bench for lcd_text_buffer: directed scenarios plus a random byte stream,
// all checked cycle by cycle against a behavioural image/cursor model.
module tb_lcd_text_buffer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lcd_text_buffer_if bus();

  lcd_text_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: image, which cells hold a defined value, cursor,
  // dirty flag, cells still to be cleared, and the expected read data.
  logic [7:0] mem_m [32];
  bit         known_m [32];
  logic [4:0] cur_m;
  logic       dirty_m;
  int         clr_left;
  logic [7:0] rd_m;
  bit         rd_known;
  bit         accepted_last;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    clr_left = 32;
    cur_m    = 5'd0;
    dirty_m  = 1'b0;
    rd_m     = 8'h00;
    rd_known = 1'b1;
  endtask

  // Effect of one clock edge given the inputs presented before it.
  task automatic model_edge(input logic v, input logic [7:0] ch, input logic fd, input logic [4:0] ra);
    logic [7:0] rd_new;
    bit         rk;
    bit         set;
    int         idx;
    rd_new = mem_m[ra];
    rk     = known_m[ra];
    set    = 1'b0;
    accepted_last = 1'b0;
    if (clr_left > 0) begin
      idx = 32 - clr_left;
      mem_m[idx]   = 8'h20;
      known_m[idx] = 1'b1;
      clr_left--;
      if (clr_left == 0) set = 1'b1;
    end else if (v) begin
      accepted_last = 1'b1;
      if (ch >= 8'h20 && ch <= 8'h7E) begin
        mem_m[cur_m]   = ch;
        known_m[cur_m] = 1'b1;
        cur_m = cur_m + 5'd1;
        set = 1'b1;
      end else if (ch == 8'h0D) begin
        cur_m = cur_m & 5'h10;
      end else if (ch == 8'h0A) begin
        cur_m = cur_m ^ 5'h10;
      end else if (ch == 8'h08) begin
        if (cur_m != 5'd0) begin
          cur_m = cur_m - 5'd1;
          mem_m[cur_m]   = 8'h20;
          known_m[cur_m] = 1'b1;
          set = 1'b1;
        end
      end else if (ch == 8'h0C) begin
        cur_m    = 5'd0;
        clr_left = 32;
      end
    end
    if (set)
      dirty_m = 1'b1;
    else if (fd)
      dirty_m = 1'b0;
    rd_m     = rd_new;
    rd_known = rk;
  endtask

  task automatic compare_model();
    check_val("in_ready", 32'(bus.in_ready), 32'(clr_left == 0));
    check_val("busy",     32'(bus.busy),     32'(clr_left != 0));
    check_val("cursor",   32'(bus.cursor),   32'(cur_m));
    check_val("dirty",    32'(bus.dirty),    32'(dirty_m));
    if (rd_known)
      check_val("rd_data", 32'(bus.rd_data), 32'(rd_m));
  endtask

  // One clock: drive inputs, let the edge happen, update model, compare.
  task automatic step(input logic v, input logic [7:0] ch, input logic fd, input logic [4:0] ra);
    bus.in_valid   = v;
    bus.in_char    = ch;
    bus.frame_done = fd;
    bus.rd_addr    = ra;
    @(posedge clk);
    model_edge(v, ch, fd, ra);
    #1;
    compare_model();
    $display("t=%0t v=%0b ch=%02h fd=%0b ra=%0d -> rdy=%0b cur=%0d dirty=%0b rd=%02h",
             $time, v, ch, fd, ra, bus.in_ready, bus.cursor, bus.dirty, bus.rd_data);
  endtask

  task automatic idle_step(input logic [4:0] ra);
    step(1'b0, 8'h00, 1'b0, ra);
  endtask

  // Hold a byte until it is accepted, bounded.
  task automatic send_byte(input logic [7:0] ch, input logic fd);
    int n;
    n = 0;
    do begin
      step(1'b1, ch, fd, 5'($urandom_range(0, 31)));
      n++;
    end while (!accepted_last && n < 40);
    if (!accepted_last)
      check_val("accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], 1'b0);
  endtask

  // Number of cycles until in_ready rises, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      idle_step(5'($urandom_range(0, 31)));
      n++;
    end
  endtask

  task automatic read_cell(input string tag, input logic [4:0] a, input logic [7:0] exp);
    idle_step(a);
    check_val(tag, 32'(bus.rd_data), 32'(exp));
  endtask

  initial begin
    int n;
    int r;
    logic [7:0] ch;
    for (int i = 0; i < 32; i++) begin
      known_m[i] = 1'b0;
      mem_m[i]   = 8'h00;
    end
    bus.in_valid   = 1'b0;
    bus.in_char    = 8'h00;
    bus.frame_done = 1'b0;
    bus.rd_addr    = 5'd0;

    // Reset state.
    #1;
    model_reset();
    check_val("rst_ready",  32'(bus.in_ready), 32'(0));
    check_val("rst_busy",   32'(bus.busy),     32'(1));
    check_val("rst_dirty",  32'(bus.dirty),    32'(0));
    check_val("rst_cursor", 32'(bus.cursor),   32'(0));
    check_val("rst_rd",     32'(bus.rd_data),  32'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Post-reset clear: 32 cycles busy, then blank screen.
    wait_ready(n);
    check_val("post_rst_clear_len", 32'(n), 32'(32));
    check_val("post_rst_dirty", 32'(bus.dirty), 32'(1));
    check_val("post_rst_cursor", 32'(bus.cursor), 32'(0));
    for (int i = 0; i < 32; i++)
      read_cell("blank_cell", 5'(i), 8'h20);

    // HELLO / frame_done / LF CR / 2022.
    send_str("HELLO");
    idle_step(5'd0);
    bus.frame_done = 1'b1;
    step(1'b0, 8'h00, 1'b1, 5'd0);
    check_val("fd_clears_dirty", 32'(bus.dirty), 32'(0));
    send_byte(8'h0A, 1'b0);
    send_byte(8'h0D, 1'b0);
    check_val("lfcr_no_dirty", 32'(bus.dirty), 32'(0));
    check_val("lfcr_cursor", 32'(bus.cursor), 32'(16));
    send_str("2022");
    read_cell("hello_0", 5'd0, 8'h48);
    read_cell("hello_4", 5'd4, 8'h4F);
    read_cell("l2_16", 5'd16, 8'h32);
    read_cell("l2_17", 5'd17, 8'h30);
    read_cell("l2_19", 5'd19, 8'h32);
    check_val("hello_cursor", 32'(bus.cursor), 32'(20));
    check_val("hello_dirty", 32'(bus.dirty), 32'(1));

    // 33 bytes from a cleared screen: wrap overwrites cell 0.
    send_byte(8'h0C, 1'b0);
    wait_ready(n);
    for (int i = 0; i <= 32; i++)
      send_byte(8'h41 + 8'(i), 1'b0);
    read_cell("wrap_cell0", 5'd0, 8'h61);
    read_cell("wrap_cell31", 5'd31, 8'h60);
    check_val("wrap_cursor", 32'(bus.cursor), 32'(1));

    // Backspace at home, then after "AB" together with frame_done.
    send_byte(8'h0C, 1'b0);
    wait_ready(n);
    send_byte(8'h08, 1'b0);
    check_val("bs_home_cursor", 32'(bus.cursor), 32'(0));
    read_cell("bs_home_cell0", 5'd0, 8'h20);
    send_str("AB");
    send_byte(8'h08, 1'b1);
    check_val("bs_fd_dirty", 32'(bus.dirty), 32'(1));
    check_val("bs_cursor", 32'(bus.cursor), 32'(1));
    read_cell("bs_cell1", 5'd1, 8'h20);
    read_cell("bs_cell0", 5'd0, 8'h41);

    // FF after filling: exactly 32 busy cycles, blank result.
    send_str("FILLED LINE ONE!SECOND LINE TEXT");
    send_byte(8'h0C, 1'b0);
    wait_ready(n);
    check_val("ff_clear_len", 32'(n), 32'(32));
    check_val("ff_cursor", 32'(bus.cursor), 32'(0));
    for (int i = 0; i < 32; i++)
      read_cell("ff_blank", 5'(i), 8'h20);

    // Reset in the middle of a clear (clr_cnt = 10).
    send_str("XYZ");
    send_byte(8'h0C, 1'b0);
    for (int i = 0; i < 10; i++)
      idle_step(5'd0);
    rst = 1'b0;
    #1;
    model_reset();
    check_val("midrst_dirty", 32'(bus.dirty), 32'(0));
    check_val("midrst_busy", 32'(bus.busy), 32'(1));
    check_val("midrst_cursor", 32'(bus.cursor), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 16; i++)
      idle_step(5'd0);
    check_val("midrst_dirty_during", 32'(bus.dirty), 32'(0));
    n = 16;
    begin
      int m;
      wait_ready(m);
      n = n + m;
    end
    check_val("midrst_clear_len", 32'(n), 32'(32));
    check_val("midrst_dirty_after", 32'(bus.dirty), 32'(1));

    // Read-before-write on the cell being written.
    step(1'b1, 8'h5A, 1'b0, 5'd0);
    check_val("rbw_old", 32'(bus.rd_data), 32'(8'h20));
    idle_step(5'd0);
    check_val("rbw_new", 32'(bus.rd_data), 32'(8'h5A));

    // Random traffic.
    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 99);
      if (r < 60)       ch = 8'($urandom_range(32, 126));
      else if (r < 68)  ch = 8'h0D;
      else if (r < 76)  ch = 8'h0A;
      else if (r < 88)  ch = 8'h08;
      else if (r < 90)  ch = 8'h0C;
      else              ch = 8'($urandom_range(0, 255));
      step(1'($urandom_range(0, 9) < 7), ch, 1'($urandom_range(0, 4) == 0),
           5'($urandom_range(0, 31)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_text_buffer.md
# lcd_text_buffer

Upstream character source for the 2x16 text-LCD controller. It holds a 32-cell display image and fills it from a byte stream using a valid/ready handshake, with an auto-advancing cursor and a small set of control codes. The LCD controller reads cells through a registered read port. A dirty flag tells the controller that the image changed since its last completed frame.

## Interface
- CLEAR_CHAR, 8'h20, fill value written by clear and backspace
- rst  input  1  asynchronous, active-low reset
- clk  input  1  clock; all logic on posedge clk
- in_valid  input  1  in_char holds a byte to consume
- in_char  input  8  ASCII byte or control code
- in_ready  output  1  buffer can accept a byte this cycle
- rd_addr  input  5  cell index; bit 4 = line (0 = line 1, 1 = line 2), bits 3:0 = column
- rd_data  output  8  contents of cell rd_addr, registered
- frame_done  input  1  one-cycle pulse from the LCD controller after it has written a full frame
- dirty  output  1  image changed since the last frame_done
- cursor  output  5  next cell to be written
- busy  output  1  clear sequence in progress

## Operation
- Storage: 32 x 8 array, cell index = {line, column}.
- FSM states:
  - CLEAR: writes CLEAR_CHAR to cell clr_cnt, one cell per cycle, clr_cnt 0..31. After the write to cell 31, the next state is IDLE.
  - IDLE: accepts input.
- Reset values: state = CLEAR, clr_cnt = 0, cursor = 0, dirty = 0, rd_data = 8'h00. Therefore in_ready = 0 and busy = 1 during reset.
- in_ready = (state == IDLE); busy = (state == CLEAR). Both are combinational from state.
- A byte is accepted when in_valid & in_ready. Decoding of accepted bytes:
  - 0x20–0x7E, printable: write to cell[cursor]; cursor <= cursor + 1, 5-bit wrap (31 -> 0, so line 2 end wraps to line 1 start); set dirty.
  - 0x0D, CR: cursor <= {cursor[4], 4'h0}; no write; dirty unchanged.
  - 0x0A, LF: cursor <= {~cursor[4], cursor[3:0]}; no write.
  - 0x08, BS:
    - cursor != 0: cursor <= cursor - 1; write CLEAR_CHAR to cell[cursor - 1]; set dirty.
    - cursor == 0: no effect, but the byte is still consumed.
  - 0x0C, FF: cursor <= 0, clr_cnt <= 0, state <= CLEAR.
  - Any other byte: consumed and discarded, no state change.
- On CLEAR -> IDLE transition: set dirty.
- dirty update priority:
  - A set event and frame_done in the same cycle leave dirty = 1.
  - frame_done alone clears dirty.
  - frame_done while busy is honoured the same way (clears dirty unless a set event occurs that cycle).
- Read port: rd_data <= cell[rd_addr] on every posedge, independent of state.
  - A read and a write to the same cell in the same cycle return the old contents (read-before-write).
- rst asserted mid-operation: immediate return to the reset values. Array contents are not reset directly; they are overwritten by the CLEAR sequence that follows reset.

## Timing
- Post-reset clear: edges 1..32 after reset deassertion write cells 0..31. State becomes IDLE at edge 32, so in_ready = 1 and dirty = 1 in the cycle after edge 32.
- FF clear: the FF is accepted at edge N. Cells 0..31 are written at edges N+1..N+32. in_ready is 0 from after edge N until after edge N+32.
- Printable write:
  - Cell and cursor update at the accepting edge.
  - A read of that cell issued in the next cycle shows the new value one edge later.
- Back-to-back acceptance: one byte per cycle while IDLE, with no bubbles.
- Read latency: 1 cycle from rd_addr to rd_data.
- in_char is ignored when in_ready = 0. The source must hold in_valid and in_char until the handshake completes.

## Test plan
- Reset, then poll: in_ready = 0 for 32 cycles, then 1; dirty = 1; reading all 32 cells returns 8'h20; cursor = 0.
- Stream "HELLO", pulse frame_done, then LF, CR, "2022": cells 0–4 = "HELLO", cells 16–19 = "2022", cursor = 20, dirty = 1.
- Write 33 printable bytes 'A'+i (i = 0..32): cell 0 = 'a' (0x61, overwritten by the 33rd byte), cell 31 = 0x60, cursor = 1.
- BS at cursor 0 -> no change. Write "AB", then BS -> cell 1 = 0x20, cursor = 1. frame_done issued in the same cycle as the BS acceptance -> dirty stays 1.
- FF after filling cells: in_ready low for exactly 32 cycles; all cells read 0x20; cursor = 0. Assert rst during the clear at clr_cnt = 10 -> a full 32-cycle clear restarts and dirty = 0 until it completes.
- Read the cell being written in the accepting cycle -> old value; the next read -> new value.
